count_report_tx: RTL and testbench

//  Downstream of the dual event counter. On request, snapshots both counter

---
 rtl/count_report_tx.sv | 150 +++++++++++++++
 tb/tb_count_report_tx.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/count_report_tx.sv
// Snapshots two event counters on request and streams them out as a byte frame:
// header, Count0 LSB-first, Count1 LSB-first, then an XOR checksum of the data bytes.
module count_report_tx #(
  parameter int unsigned CNT_W  = 64,
  parameter logic [7:0]  HEADER = 8'hA5
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Req,
  input  logic [CNT_W-1:0] Count0,
  input  logic [CNT_W-1:0] Count1,
  output logic [7:0]       TxData,
  output logic             TxValid,
  input  logic             TxReady,
  output logic             Busy,
  output logic [7:0]       DropCnt
);

  localparam int unsigned   NB       = CNT_W / 8;
  localparam int unsigned   IW       = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NB - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_C0   = 3'd2,
    S_C1   = 3'd3,
    S_CHK  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0] snap0_q, snap0_d;
  logic [CNT_W-1:0] snap1_q, snap1_d;
  logic [7:0]       chk_q, chk_d;
  logic [7:0]       drop_q, drop_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_valid_q, tx_valid_d;
  logic             xfer_s;

  function automatic logic [7:0] byte_sel(input logic [CNT_W-1:0] v, input logic [IW-1:0] k);
    logic [CNT_W-1:0] sh;
    sh = v >> {k, 3'b000};
    return sh[7:0];
  endfunction

  assign xfer_s = tx_valid_q & TxReady;

  // Frame sequencing, checksum accumulation, drop counting and next output byte
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    snap0_d    = snap0_q;
    snap1_d    = snap1_q;
    chk_d      = chk_q;
    drop_d     = drop_q;
    tx_data_d  = 8'h00;
    tx_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (Req) begin
          snap0_d = Count0;
          snap1_d = Count1;
          chk_d   = 8'h00;
          idx_d   = '0;
          state_d = S_HDR;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_HDR: begin
        if (xfer_s) begin
          idx_d   = '0;
          state_d = S_C0;
        end else begin
          state_d = S_HDR;
        end
      end
      S_C0, S_C1: begin
        if (xfer_s) begin
          // tx_data_q holds the data byte being accepted right now
          chk_d = chk_q ^ tx_data_q;
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = (state_q == S_C0) ? S_C1 : S_CHK;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end else begin
          state_d = state_q;
        end
      end
      S_CHK: begin
        if (xfer_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_CHK;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (Req && (state_q != S_IDLE) && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end else begin
      drop_d = drop_q;
    end

    case (state_d)
      S_HDR:   tx_data_d = HEADER;
      S_C0:    tx_data_d = byte_sel(snap0_d, idx_d);
      S_C1:    tx_data_d = byte_sel(snap1_d, idx_d);
      S_CHK:   tx_data_d = chk_d;
      default: tx_data_d = 8'h00;
    endcase
    tx_valid_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      snap0_q    <= '0;
      snap1_q    <= '0;
      chk_q      <= 8'h00;
      drop_q     <= 8'h00;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      snap0_q    <= snap0_d;
      snap1_q    <= snap1_d;
      chk_q      <= chk_d;
      drop_q     <= drop_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
    end
  end

  assign TxData  = tx_data_q;
  assign TxValid = tx_valid_q;
  assign Busy    = (state_q != S_IDLE);
  assign DropCnt = drop_q;

endmodule

// File: tb/tb_count_report_tx.sv
// Scoreboard bench for count_report_tx: expected frame bytes are queued when a
// request is driven and compared as the DUT transfers them.
module tb_count_report_tx;

  localparam int CNT_W = 64;

  logic             Clk;
  logic             Reset;
  logic             Req;
  logic [CNT_W-1:0] Count0;
  logic [CNT_W-1:0] Count1;
  logic [7:0]       TxData;
  logic             TxValid;
  logic             TxReady;
  logic             Busy;
  logic [7:0]       DropCnt;

  int         checks = 0;
  int         errors = 0;
  int         xfer_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] last_byte = 8'h00;
  logic       stall_prev = 1'b0;
  logic [7:0] stall_data = 8'h00;

  count_report_tx #(.CNT_W(CNT_W), .HEADER(8'hA5)) dut (
    .Clk(Clk), .Reset(Reset), .Req(Req), .Count0(Count0), .Count1(Count1),
    .TxData(TxData), .TxValid(TxValid), .TxReady(TxReady), .Busy(Busy), .DropCnt(DropCnt)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Transfer monitor: pops the scoreboard, checks hold stability and Busy/TxValid agreement
  always @(negedge Clk) begin
    if (!Reset) begin
      checks++;
      if (Busy !== TxValid) begin
        errors++;
        $display("FAIL busy_eq_valid: Busy=%0b TxValid=%0b", Busy, TxValid);
      end
      if (stall_prev) begin
        checks++;
        if (TxValid !== 1'b1 || TxData !== stall_data) begin
          errors++;
          $display("FAIL hold_stable: TxValid=%0b TxData=%02h required 1/%02h", TxValid, TxData, stall_data);
        end
      end
      if (TxValid === 1'b1 && TxReady === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_byte: TxData=%02h with empty scoreboard", TxData);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (TxData !== e) begin
            errors++;
            $display("FAIL frame_byte: got %02h required %02h", TxData, e);
          end
        end
        last_byte = TxData;
        xfer_cnt++;
      end
      stall_prev = (TxValid === 1'b1) && (TxReady === 1'b0);
      stall_data = TxData;
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic push_frame(input logic [CNT_W-1:0] c0, input logic [CNT_W-1:0] c1);
    logic [7:0] b;
    logic [7:0] x;
    x = 8'h00;
    exp_q.push_back(8'hA5);
    for (int k = 0; k < CNT_W/8; k++) begin
      b = c0[k*8 +: 8];
      x = x ^ b;
      exp_q.push_back(b);
    end
    for (int k = 0; k < CNT_W/8; k++) begin
      b = c1[k*8 +: 8];
      x = x ^ b;
      exp_q.push_back(b);
    end
    exp_q.push_back(x);
  endtask

  // Pulses Req for one cycle; returns just after the capture edge
  task automatic start_frame(input logic [CNT_W-1:0] c0, input logic [CNT_W-1:0] c1);
    Count0 = c0;
    Count1 = c1;
    Req = 1'b1;
    push_frame(c0, c1);
    @(posedge Clk); #1;
    Req = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int c;
    c = 0;
    while ((exp_q.size() != 0 || TxValid === 1'b1) && c < budget) begin
      @(posedge Clk); #1;
      c++;
    end
    checks++;
    if (c >= budget) begin
      errors++;
      $display("FAIL drain_timeout: %0d bytes left after %0d cycles, required 0", exp_q.size(), c);
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1; Req = 1'b0; TxReady = 1'b0; Count0 = '0; Count1 = '0;
    repeat (3) @(posedge Clk);
    #1;
    checks++;
    if (TxValid !== 1'b0 || Busy !== 1'b0 || TxData !== 8'h00 || DropCnt !== 8'h00) begin
      errors++;
      $display("FAIL reset_state: valid=%0b busy=%0b data=%02h drop=%02h required 0/0/00/00",
               TxValid, Busy, TxData, DropCnt);
    end
    Reset = 1'b0;
    @(posedge Clk); #1;
  endtask

  task automatic test_basic();
    int base;
    int cyc;
    TxReady = 1'b1;
    Count0 = 64'h0102030405060708;
    Count1 = 64'h0;
    Req = 1'b1;
    push_frame(Count0, Count1);
    base = xfer_cnt;
    @(negedge Clk);
    checks++;
    if (TxValid !== 1'b0) begin
      errors++;
      $display("FAIL req_latency_early: TxValid=%0b in Req cycle, required 0", TxValid);
    end
    @(posedge Clk); #1;
    Req = 1'b0;
    checks++;
    if (TxValid !== 1'b1 || TxData !== 8'hA5) begin
      errors++;
      $display("FAIL req_latency: TxValid=%0b TxData=%02h required 1/A5", TxValid, TxData);
    end
    cyc = 0;
    while (Busy === 1'b1 && cyc < 100) begin
      @(posedge Clk); #1;
      cyc++;
    end
    checks++;
    if (cyc != 18 || (xfer_cnt - base) != 18) begin
      errors++;
      $display("FAIL basic_length: %0d cycles %0d transfers, required 18/18", cyc, xfer_cnt - base);
    end
    checks++;
    if (last_byte !== 8'h08) begin
      errors++;
      $display("FAIL basic_checksum: got %02h required 08", last_byte);
    end
    wait_idle(10);
  endtask

  task automatic test_stall();
    int base;
    int i;
    TxReady = 1'b0;
    base = xfer_cnt;
    start_frame(64'h0102030405060708, 64'h0);
    i = 0;
    while (Busy === 1'b1 && i < 200) begin
      TxReady = ((i % 4) == 0) || ((i % 4) == 3);
      @(posedge Clk); #1;
      i++;
    end
    checks++;
    if ((xfer_cnt - base) != 18) begin
      errors++;
      $display("FAIL stall_count: %0d transfers required 18", xfer_cnt - base);
    end
    TxReady = 1'b1;
    wait_idle(10);
  endtask

  task automatic test_snapshot();
    TxReady = 1'b1;
    start_frame(64'h0102030405060708, 64'h0);
    Count0 = 64'hFFFF_FFFF_FFFF_FFFF;
    Count1 = 64'hFFFF_FFFF_FFFF_FFFF;
    wait_idle(40);
    checks++;
    if (last_byte !== 8'h08) begin
      errors++;
      $display("FAIL snapshot_checksum: got %02h required 08", last_byte);
    end
  endtask

  task automatic test_drops();
    int base;
    logic [CNT_W-1:0] c0b;
    logic [CNT_W-1:0] c1b;
    Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    TxReady = 1'b1;
    c0b = {$urandom, $urandom};
    c1b = {$urandom, $urandom};
    base = xfer_cnt;
    start_frame(64'h1122334455667788, 64'h99AABBCCDDEEFF00);
    for (int j = 0; j <= 18; j++) begin
      Req = (j == 3 || j == 6 || j == 9 || j == 17 || j == 18);
      if (j == 17) begin
        checks++;
        if (Busy !== 1'b1) begin
          errors++;
          $display("FAIL drop_chk_busy: Busy=%0b in CHK cycle, required 1", Busy);
        end
      end
      if (j == 18) begin
        checks++;
        if (Busy !== 1'b0 || DropCnt !== 8'd4 || (xfer_cnt - base) != 18) begin
          errors++;
          $display("FAIL drop_count: busy=%0b drop=%0d transfers=%0d required 0/4/18",
                   Busy, DropCnt, xfer_cnt - base);
        end
        Count0 = c0b;
        Count1 = c1b;
        push_frame(c0b, c1b);
      end
      @(posedge Clk); #1;
    end
    Req = 1'b0;
    checks++;
    if (TxValid !== 1'b1 || TxData !== 8'hA5) begin
      errors++;
      $display("FAIL frame2_start: TxValid=%0b TxData=%02h required 1/A5", TxValid, TxData);
    end
    wait_idle(40);
    checks++;
    if (DropCnt !== 8'd4) begin
      errors++;
      $display("FAIL drop_after: DropCnt=%0d required 4", DropCnt);
    end
  endtask

  task automatic test_reset_mid();
    int base;
    TxReady = 1'b1;
    base = xfer_cnt;
    start_frame(64'hDEADBEEF_CAFEF00D, 64'h0123456789ABCDEF);
    repeat (5) begin
      @(posedge Clk); #1;
    end
    checks++;
    if ((xfer_cnt - base) != 5) begin
      errors++;
      $display("FAIL midreset_pre: %0d transfers required 5", xfer_cnt - base);
    end
    Reset = 1'b1;
    TxReady = 1'b0;
    @(posedge Clk); #1;
    checks++;
    if (TxValid !== 1'b0 || Busy !== 1'b0 || DropCnt !== 8'h00 || TxData !== 8'h00) begin
      errors++;
      $display("FAIL midreset_state: valid=%0b busy=%0b drop=%02h data=%02h required 0/0/00/00",
               TxValid, Busy, DropCnt, TxData);
    end
    exp_q.delete();
    Reset = 1'b0;
    TxReady = 1'b1;
    repeat (3) begin
      @(posedge Clk); #1;
      checks++;
      if (TxValid !== 1'b0) begin
        errors++;
        $display("FAIL midreset_resume: TxValid=%0b after reset, required 0", TxValid);
      end
    end
    start_frame(64'h00000000_000000FF, 64'h80000000_00000001);
    wait_idle(40);
  endtask

  task automatic test_saturate();
    logic [7:0] exp_drop;
    TxReady = 1'b0;
    exp_drop = DropCnt;
    start_frame(64'h0F0E0D0C0B0A0908, 64'h0706050403020100);
    for (int p = 0; p < 300; p++) begin
      Req = 1'b1;
      @(posedge Clk); #1;
      Req = 1'b0;
      if (exp_drop != 8'hFF) exp_drop = exp_drop + 8'd1;
      checks++;
      if (DropCnt !== exp_drop || TxValid !== 1'b1 || TxData !== 8'hA5) begin
        errors++;
        $display("FAIL saturate_step%0d: drop=%02h valid=%0b data=%02h required %02h/1/A5",
                 p, DropCnt, TxValid, TxData, exp_drop);
      end
      @(posedge Clk); #1;
    end
    checks++;
    if (DropCnt !== 8'hFF) begin
      errors++;
      $display("FAIL saturate_final: DropCnt=%02h required FF", DropCnt);
    end
    TxReady = 1'b1;
    wait_idle(40);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_snapshot();
    test_drops();
    test_reset_mid();
    test_saturate();
    repeat (2) @(posedge Clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
